vga_sync_ctrl: RTL and testbench
================================

# vga_sync_ctrl

VGA timing controller that sequences the pixel datapath of the pong display. Consumes the one-cycle 25 MHz pixel-enable pulse produced by `clkdiv` in the 100 MHz domain and steps the horizontal/vertical scan counters. Generates hsync/vsync, the active-video flag, and line/frame strobes for the paddle, ball and score renderers. All logic runs on the single 100 MHz clock; there are no derived clocks.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk`  in  1  100 MHz system clock; all state updates on its rising edge
- `rst`  in  1  reset; synchronous, active-low
- `pix_en`  in  1  pixel-enable pulse from `clkdiv` (`clk_25MGHz`); counters advance only when it is high
- `hcount`  out  10  current pixel column, 0 .. H_TOTAL-1
- `vcount`  out  10  current line, 0 .. V_TOTAL-1
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `video_on`  out  1  high when (hcount, vcount) is in the visible region
- `line_tick`  out  1  one-clk strobe on hcount wrap
- `frame_tick`  out  1  one-clk strobe on frame wrap (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal phase FSM: ACTIVE → FP → SYNC → BP → ACTIVE. Transitions occur on pix_en cycles at hcount boundaries 640 / 656 / 752 / 0. The vertical FSM uses the same four states at vcount 480 / 490 / 492 / 0 and advances only on the horizontal wrap. The FSM state may be decoded from the counters, but behaviour must match the boundaries above.
- On a pix_en cycle:
  - If hcount < H_TOTAL-1: hcount += 1.
  - Otherwise: hcount ← 0, and vcount increments, wrapping V_TOTAL-1 → 0.
- When pix_en is low, all counters and outputs hold. The two strobes are the exception: they deassert.
- hsync = 0 iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync = 0 iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
- video_on = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- All outputs are registered. Decodes are computed from next-state counter values, so hsync, vsync and video_on always match the hcount/vcount presented in the same cycle.
- Counter arithmetic is 10-bit unsigned. Parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024. Counters never reach H_TOTAL or V_TOTAL.
- pix_en held continuously high is legal: the counters then advance every clk (fast-sim mode).

## Timing
- Reset values (rst low on a clk edge): hcount=0, vcount=0, hsync=1, vsync=1, video_on=1, line_tick=0, frame_tick=0.
- Reset has priority over pix_en in the same cycle. Reset asserted mid-frame returns all state to the reset values on that edge, with no partial-line completion.
- Latency: counters and decodes update on the same edge that samples pix_en=1. There is no additional pipeline delay.
- line_tick = 1 for exactly the one clk following the edge where hcount went H_TOTAL-1 → 0. It is 0 otherwise, including after reset.
- frame_tick obeys the same rule for the edge where (hcount, vcount) went (H_TOTAL-1, V_TOTAL-1) → (0, 0). line_tick is also 1 in that cycle.
- With pix_en every 4th clk: one line = 3200 clk, one frame = 1,680,000 clk.

## Configuration
- Macro `VGA_FRAME_TICK_EN`.
- Defined: frame_tick is generated as described in Timing.
- Undefined: frame_tick is tied to 0, and the frame-wrap detect logic is not synthesised. All other behaviour is unchanged.

## Test plan
- Hold rst low 3 clks with pix_en toggling → hcount=0, vcount=0, hsync=1, vsync=1, video_on=1, both ticks 0, throughout reset and on the first clk after release.
- Drive pix_en as the 1-in-4 pulse and count 640 pix_en pulses from reset → hcount=640 and video_on=0. After 656 pulses hsync=0. After 752 pulses hsync=1. After 800 pulses hcount=0, vcount=1, line_tick=1 for one clk.
- Hold pix_en low 50 clks mid-line at hcount=300 → hcount stays 300, and all outputs are stable with ticks 0.
- Hold pix_en high continuously → vsync=0 exactly while vcount ∈ {490, 491}. frame_tick=1 once at clk 420,000 after reset (with `VGA_FRAME_TICK_EN`). Without the macro, frame_tick stays 0 throughout.
- Assert rst at hcount=700, vcount=300 → next edge gives reset values. After release, counting restarts from (0,0), and the first line_tick occurs 800 pix_en pulses later.
- Across 2 full frames, for every cycle, check video_on/hsync/vsync against the same-cycle hcount/vcount using the Operation formulas → zero mismatches.

Source files
------------

// File: rtl/vga_sync_ctrl.sv
// VGA scan-counter and sync generator for the pong display, stepped by the 25 MHz pixel enable.
// Define VGA_FRAME_TICK_EN to build the frame-wrap strobe; otherwise frame_tick is tied low.
module vga_sync_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_AT = 10'(H_ACTIVE);
    localparam logic [9:0] H_SY_AT = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_AT = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_AT = 10'(V_ACTIVE);
    localparam logic [9:0] V_SY_AT = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_AT = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    phase_e     hst_q, hst_d;
    phase_e     vst_q, vst_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       von_q, von_d;
    logic       line_q, line_d;
    logic       h_wrap;

    // Scan counters
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        h_wrap = 1'b0;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d    = '0;
                h_wrap = 1'b1;
                v_d    = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Phase FSMs step on the next-state count so decodes line up with it
    always_comb begin
        hst_d = hst_q;
        if (pix_en) begin
            unique case (hst_q)
                PH_ACTIVE: if (h_d == H_FP_AT) hst_d = PH_FP;
                PH_FP:     if (h_d == H_SY_AT) hst_d = PH_SYNC;
                PH_SYNC:   if (h_d == H_BP_AT) hst_d = PH_BP;
                PH_BP:     if (h_d == '0)      hst_d = PH_ACTIVE;
                default:   hst_d = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        vst_d = vst_q;
        if (h_wrap) begin
            unique case (vst_q)
                PH_ACTIVE: if (v_d == V_FP_AT) vst_d = PH_FP;
                PH_FP:     if (v_d == V_SY_AT) vst_d = PH_SYNC;
                PH_SYNC:   if (v_d == V_BP_AT) vst_d = PH_BP;
                PH_BP:     if (v_d == '0)      vst_d = PH_ACTIVE;
                default:   vst_d = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        hsync_d = (hst_d != PH_SYNC);
        vsync_d = (vst_d != PH_SYNC);
        von_d   = (hst_d == PH_ACTIVE) && (vst_d == PH_ACTIVE);
        line_d  = h_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q     <= '0;
            v_q     <= '0;
            hst_q   <= PH_ACTIVE;
            vst_q   <= PH_ACTIVE;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            von_q   <= 1'b1;
            line_q  <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hst_q   <= hst_d;
            vst_q   <= vst_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            von_q   <= von_d;
            line_q  <= line_d;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic frame_q, frame_d;

    assign frame_d = h_wrap && (v_q == V_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_tick = frame_q;
`else
    assign frame_tick = 1'b0;
`endif

    assign hcount    = h_q;
    assign vcount    = v_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = von_q;
    assign line_tick = line_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench: a default-timing instance for line-level checks and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_sync_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pix_en_a, pix_en_b;
    logic [9:0] hc_a, vc_a, hc_b, vc_b;
    logic       hs_a, vs_a, vo_a, lt_a, ft_a;
    logic       hs_b, vs_b, vo_b, lt_b, ft_b;

    int tests = 0;
    int fails = 0;

`ifdef VGA_FRAME_TICK_EN
    localparam bit FT_EN = 1'b1;
`else
    localparam bit FT_EN = 1'b0;
`endif

    vga_sync_ctrl u_a (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en_a),
        .hcount     (hc_a),
        .vcount     (vc_a),
        .hsync      (hs_a),
        .vsync      (vs_a),
        .video_on   (vo_a),
        .line_tick  (lt_a),
        .frame_tick (ft_a)
    );

    // H_TOTAL = 30 (sync 20..25), V_TOTAL = 19 (sync 14..15)
    vga_sync_ctrl #(
        .H_ACTIVE (16),
        .H_FP     (4),
        .H_SYNC   (6),
        .H_BP     (4),
        .V_ACTIVE (12),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en_b),
        .hcount     (hc_b),
        .vcount     (vc_b),
        .hsync      (hs_b),
        .vsync      (vs_b),
        .video_on   (vo_b),
        .line_tick  (lt_b),
        .frame_tick (ft_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input bit b, input string tag,
                           input int eh, input int ev,
                           input bit ehs, input bit evs, input bit evo,
                           input bit elt, input bit eft);
        if (!b) begin
            chk({tag, ".hcount"}, 32'(hc_a), eh);
            chk({tag, ".vcount"}, 32'(vc_a), ev);
            chk({tag, ".hsync"}, 32'(hs_a), 32'(ehs));
            chk({tag, ".vsync"}, 32'(vs_a), 32'(evs));
            chk({tag, ".video_on"}, 32'(vo_a), 32'(evo));
            chk({tag, ".line_tick"}, 32'(lt_a), 32'(elt));
            chk({tag, ".frame_tick"}, 32'(ft_a), 32'(eft));
        end else begin
            chk({tag, ".hcount"}, 32'(hc_b), eh);
            chk({tag, ".vcount"}, 32'(vc_b), ev);
            chk({tag, ".hsync"}, 32'(hs_b), 32'(ehs));
            chk({tag, ".vsync"}, 32'(vs_b), 32'(evs));
            chk({tag, ".video_on"}, 32'(vo_b), 32'(evo));
            chk({tag, ".line_tick"}, 32'(lt_b), 32'(elt));
            chk({tag, ".frame_tick"}, 32'(ft_b), 32'(eft));
        end
    endtask

    // 1-in-4 pixel enable; returns just after the pulse edge
    task automatic pulses(input bit b, input int n);
        repeat (n) begin
            tick();
            tick();
            tick();
            if (b) pix_en_b = 1'b1;
            else   pix_en_a = 1'b1;
            tick();
            pix_en_a = 1'b0;
            pix_en_b = 1'b0;
        end
    endtask

    initial begin
        int h, v, vs_low, ft_seen, first_ft;
        bit lt, ft;

        rst      = 1'b0;
        pix_en_a = 1'b0;
        pix_en_b = 1'b0;

        for (int i = 0; i < 3; i++) begin
            pix_en_a = i[0];
            pix_en_b = i[0];
            tick();
            chk_out(0, "rst_a", 0, 0, 1, 1, 1, 0, 0);
            chk_out(1, "rst_b", 0, 0, 1, 1, 1, 0, 0);
        end
        rst      = 1'b1;
        pix_en_a = 1'b0;
        pix_en_b = 1'b0;
        tick();
        chk_out(0, "release_a", 0, 0, 1, 1, 1, 0, 0);
        chk_out(1, "release_b", 0, 0, 1, 1, 1, 0, 0);

        pulses(0, 639);
        chk_out(0, "h639", 639, 0, 1, 1, 1, 0, 0);
        pulses(0, 1);
        chk_out(0, "h640", 640, 0, 1, 1, 0, 0, 0);
        pulses(0, 15);
        chk_out(0, "h655", 655, 0, 1, 1, 0, 0, 0);
        pulses(0, 1);
        chk_out(0, "h656", 656, 0, 0, 1, 0, 0, 0);
        pulses(0, 95);
        chk_out(0, "h751", 751, 0, 0, 1, 0, 0, 0);
        pulses(0, 1);
        chk_out(0, "h752", 752, 0, 1, 1, 0, 0, 0);
        pulses(0, 47);
        chk_out(0, "h799", 799, 0, 1, 1, 0, 0, 0);
        pulses(0, 1);
        chk_out(0, "wrap", 0, 1, 1, 1, 1, 1, 0);
        tick();
        chk_out(0, "wrap_next", 0, 1, 1, 1, 1, 0, 0);

        pulses(0, 300);
        chk_out(0, "h300", 300, 1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk_out(0, "hold", 300, 1, 1, 1, 1, 0, 0);
        end

        // Two full frames with pix_en held high on the small instance
        h        = 0;
        v        = 0;
        vs_low   = 0;
        ft_seen  = 0;
        first_ft = -1;
        pix_en_b = 1'b1;
        for (int c = 1; c <= 1140; c++) begin
            tick();
            lt = 1'b0;
            ft = 1'b0;
            if (h == 29) begin
                h  = 0;
                lt = 1'b1;
                if (v == 18) begin
                    v  = 0;
                    ft = FT_EN;
                end else begin
                    v++;
                end
            end else begin
                h++;
            end
            chk_out(1, "scan", h, v, !(h >= 20 && h < 26),
                    !(v >= 14 && v < 16), (h < 16 && v < 12), lt, ft);
            if (vs_b == 1'b0) vs_low++;
            if (ft_b == 1'b1) begin
                ft_seen++;
                if (first_ft < 0) first_ft = c;
            end
        end
        chk("vsync_low_cycles", vs_low, 120);
        chk("frame_tick_count", ft_seen, FT_EN ? 2 : 0);
        chk("first_frame_tick_clk", first_ft, FT_EN ? 570 : -1);

        repeat (325) tick();
        chk_out(1, "pre_rst", 25, 10, 0, 1, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_out(1, "mid_rst", 0, 0, 1, 1, 1, 0, 0);
        rst      = 1'b1;
        pix_en_b = 1'b0;
        tick();
        chk_out(1, "mid_release", 0, 0, 1, 1, 1, 0, 0);
        pulses(1, 29);
        chk_out(1, "re_h29", 29, 0, 1, 1, 0, 0, 0);
        pulses(1, 1);
        chk_out(1, "re_wrap", 0, 1, 1, 1, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
